// File: rtl/clock_pkg.sv
// Shared definitions for the clock mode controller: mode encodings, digit-field layout, defaults.
// Honours MODE_CTRL_ALARM_EN (ALARM mode present when defined).
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_CLOCK = 2'b00,
        MODE_SET   = 2'b01,
        MODE_ALARM = 2'b10,
        MODE_SW    = 2'b11
    } mode_t;

    localparam int DIGITS_W  = 24;
    localparam int DIGIT_W   = 4;
    localparam int HOUR1_LSB = 20;
    localparam int HOUR2_LSB = 16;
    localparam int MIN1_LSB  = 12;
    localparam int MIN2_LSB  = 8;
    localparam int SEC1_LSB  = 4;
    localparam int SEC2_LSB  = 0;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int TIMEOUT_CYCLES_DEF  = 1024;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_CLOCK: next_mode = MODE_SET;
`ifdef MODE_CTRL_ALARM_EN
            MODE_SET:   next_mode = MODE_ALARM;
            MODE_ALARM: next_mode = MODE_SW;
`else
            MODE_SET:   next_mode = MODE_SW;
`endif
            default:    next_mode = MODE_CLOCK;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus press/release debouncer emitting one pulse per accepted press.
// Comes out of reset in the "pressed" state so a button held through reset needs a full release first.
module btn_debounce
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [1:0]    vld;
    logic          pressed;
    logic [CW-1:0] cnt;
    logic          level;
    logic          moving;

    assign level  = sync[1];
    // Only count once the synchronizer holds real samples and the level opposes the current state.
    assign moving = vld[1] && (level != pressed);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            vld     <= '0;
            pressed <= 1'b1;
            cnt     <= RELOAD;
            pulse   <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            vld   <= {vld[0], 1'b1};
            pulse <= 1'b0;
            if (!moving) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                cnt     <= RELOAD;
                pressed <= ~pressed;
                pulse   <= ~pressed;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_controller.sv
// Mode sequencer for the digital clock: debounced buttons, mode FSM with SET idle abort, routing, display mux.
// Optional ALARM mode enabled by defining MODE_CTRL_ALARM_EN.
//
//   state      | meaning
//   MODE_CLOCK | running clock shown, buttons dropped
//   MODE_SET   | editing time; leaving by mode press commits, idle timeout aborts
//   MODE_ALARM | alarm editing (only with MODE_CTRL_ALARM_EN)
//   MODE_SW    | stopwatch
module mode_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                btn_mode_raw,
    input  logic [2:0]          btn_raw,
    input  logic [DIGITS_W-1:0] time_digits,
    input  logic [DIGITS_W-1:0] set_digits,
    input  logic [DIGITS_W-1:0] alarm_digits,
    input  logic [DIGITS_W-1:0] sw_digits,
    output logic [1:0]          mode,
    output logic [2:0]          set_btn,
    output logic [2:0]          alarm_btn,
    output logic [2:0]          sw_btn,
    output logic                load_time,
    output logic [DIGITS_W-1:0] disp_digits
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_RELOAD = TW'(TIMEOUT_CYCLES - 1);

    mode_t               state_q, state_d;
    logic [TW-1:0]       idle_q, idle_d;
    logic                load_d;
    logic [2:0]          set_d, alarm_d, sw_d;
    logic [DIGITS_W-1:0] disp_d;
    logic                mode_p;
    logic [2:0]          btn_p;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_mode_raw),
        .pulse (mode_p)
    );

    for (genvar i = 0; i < 3; i++) begin : g_db_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .pulse (btn_p[i])
        );
    end

    always_comb begin
        state_d = state_q;
        idle_d  = idle_q;
        load_d  = 1'b0;
        set_d   = '0;
        alarm_d = '0;
        sw_d    = '0;
        disp_d  = time_digits;

        // A mode press pre-empts any button press landing in the same cycle.
        if (mode_p) begin
            state_d = next_mode(state_q);
            load_d  = (state_q == MODE_SET);
            idle_d  = IDLE_RELOAD;
        end else begin
            case (state_q)
                MODE_SET: begin
                    set_d = btn_p;
                    if (btn_p != '0)
                        idle_d = IDLE_RELOAD;
                    else if (idle_q == '0)
                        state_d = MODE_CLOCK;
                    else
                        idle_d = idle_q - 1'b1;
                end
`ifdef MODE_CTRL_ALARM_EN
                MODE_ALARM: alarm_d = btn_p;
`endif
                MODE_SW:    sw_d = btn_p;
                default:    ;
            endcase
        end

        case (state_q)
            MODE_SET:   disp_d = set_digits;
`ifdef MODE_CTRL_ALARM_EN
            MODE_ALARM: disp_d = alarm_digits;
`endif
            MODE_SW:    disp_d = sw_digits;
            default:    disp_d = time_digits;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MODE_CLOCK;
            idle_q      <= IDLE_RELOAD;
            load_time   <= 1'b0;
            set_btn     <= '0;
            sw_btn      <= '0;
            disp_digits <= '0;
        end else begin
            state_q     <= state_d;
            idle_q      <= idle_d;
            load_time   <= load_d;
            set_btn     <= set_d;
            sw_btn      <= sw_d;
            disp_digits <= disp_d;
        end
    end

`ifdef MODE_CTRL_ALARM_EN
    always_ff @(posedge clk) begin
        if (reset)
            alarm_btn <= '0;
        else
            alarm_btn <= alarm_d;
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{alarm_digits, alarm_d};
    assign alarm_btn    = '0;
`endif

    assign mode = state_q;

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: mode_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable-high cycles before a press is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: idle cycles in SET before automatic abort.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_mode_raw  input  1  raw mode-select button level.
REQ-006 btn_raw  input  3  raw levels of button1 [0], button2 [1] and button3 [2].
REQ-007 time_digits, set_digits, alarm_digits, sw_digits  input  24 each  BCD digits hour1[23:20], hour2, min1, min2, sec1, sec2[3:0].
REQ-008 mode  output  2  current mode; drives the set-time block's set_mode directly.
REQ-009 set_btn, alarm_btn, sw_btn  output  3 each  one-cycle button pulses routed to each feature.
REQ-010 load_time  output  1  one-cycle pulse: commit set_digits into the running clock.
REQ-011 disp_digits  output  24  digits selected for the display.

Function
REQ-012 Each of the 4 raw inputs SHALL pass a 2-flop synchronizer, then a debouncer emitting exactly one 1-cycle pulse per press, DEBOUNCE_CYCLES after the synchronized level first goes high; no further pulse until the level has been low for DEBOUNCE_CYCLES.
REQ-013 Mode FSM states: CLOCK=00, SET=01, ALARM=10, STOPWATCH=11.
REQ-014 A mode pulse SHALL advance CLOCK->SET->ALARM->STOPWATCH->CLOCK, taking effect the cycle after the pulse.
REQ-015 Leaving SET via a mode pulse SHALL assert load_time for exactly one cycle, coincident with mode first showing ALARM (or CLOCK without ALARM_EN).
REQ-016 In SET, TIMEOUT_CYCLES consecutive cycles with no button or mode pulse SHALL return the FSM to CLOCK with load_time NOT asserted (abort); any pulse reloads the idle counter.
REQ-017 Button pulses SHALL be routed only to the feature owning the current mode: SET->set_btn, ALARM->alarm_btn, STOPWATCH->sw_btn; in CLOCK all are dropped; unrouted outputs stay 0.
REQ-018 A mode pulse and a button pulse in the same cycle: the mode transition wins and the button pulse SHALL be dropped.
REQ-019 Routed button outputs SHALL be registered: pulse visible 1 cycle after the debounced pulse.
REQ-020 disp_digits SHALL be registered (1-cycle latency) from time_digits in CLOCK, set_digits in SET, alarm_digits in ALARM, sw_digits in STOPWATCH.
REQ-021 Multiple buttons pulsing in the same cycle SHALL all be forwarded together.

Reset
REQ-022 While reset is high: mode=CLOCK, all button outputs 0, load_time 0, disp_digits 0, debounce/idle counters and synchronizers cleared.
REQ-023 Reset asserted mid-SET SHALL abort without load_time; a press held across reset release SHALL not pulse until it has been released and pressed again.

Configuration
REQ-024 Macro MODE_CTRL_ALARM_EN: defined -> ALARM state present as above; undefined -> ALARM state, alarm_btn drive logic and alarm_digits mux leg removed, SET->STOPWATCH directly, alarm_btn tied 0, mode never 10.

Structure
REQ-025 Shared package clock_pkg SHALL hold the mode encodings, the 24-bit digit-field offsets and the default DEBOUNCE_CYCLES/TIMEOUT_CYCLES values.
REQ-026 Sub-module btn_debounce (synchronizer + debounce + pulse), instantiated 4 times, parameter DEBOUNCE_CYCLES.

Verification
REQ-027 DEBOUNCE_CYCLES=4: btn_raw[0] bounces 1-0-1 then holds high 20 cycles in SET -> exactly one set_btn[0] pulse.
REQ-028 Four mode presses from reset -> mode 01,10,11,00; single load_time pulse on the 01->10 transition.
REQ-029 TIMEOUT_CYCLES=32, enter SET, no presses -> mode returns to 00 at idle cycle 32, load_time never asserted.
REQ-030 Mode and button2 debounced pulses in same cycle while in ALARM -> mode becomes 11, alarm_btn and sw_btn stay 0.
REQ-031 set_digits=0x123045 in SET -> disp_digits=0x123045 one cycle later; reset mid-SET -> mode 00, disp_digits 0, no load_time.
REQ-032 Build without MODE_CTRL_ALARM_EN: mode presses cycle 00->01->11->00; alarm_btn constant 0.
